led_cmd_rx: RTL and testbench

LED_CMD_RX -- requirements
Module: led_cmd_rx

---
 rtl/led_cmd_rx_pkg.sv | 37 +++
 rtl/led_cmd_rx_uart_rx_byte.sv | 101 ++++++++++
 rtl/led_cmd_rx.sv | 64 ++++++
 tb/tb_led_cmd_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_rx_pkg.sv
// Shared types and constants for the LED command receiver: receive FSM
// encoding and the ASCII command bytes understood by the decoder.
package led_cmd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] CMD_BASE  = 8'h30;
  localparam logic [7:0] CMD_MAX   = 8'h37;
  localparam logic [7:0] CMD_CLR_U = 8'h43;
  localparam logic [7:0] CMD_CLR_L = 8'h63;

  typedef struct packed {
    logic       ok;
    logic [2:0] val;
  } cmd_dec_t;

  // '0'..'7' select a pattern, 'C'/'c' clear to 0, anything else is rejected.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
    cmd_dec_t d;
    d.ok  = 1'b0;
    d.val = 3'b000;
    if (b >= CMD_BASE && b <= CMD_MAX) begin
      d.ok  = 1'b1;
      d.val = b[2:0];
    end else if (b == CMD_CLR_U || b == CMD_CLR_L) begin
      d.ok  = 1'b1;
      d.val = 3'b000;
    end
    return d;
  endfunction

endpackage

// File: rtl/led_cmd_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, IDLE/START/DATA/STOP FSM and
// shift register. byte_ok / frame_err are strobes in the stop-sample cycle.
module uart_rx_byte
  import led_cmd_rx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_ok,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic            r_s1, r_s2;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_wait_high;
  logic            w_rx_s;
  logic            w_tick;

  assign w_rx_s = r_s2;
  assign w_tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  // r_wait_high holds off a new start after a low stop bit so a held-low
  // line (break) reports one frame error, not one per 10-bit window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_wait_high <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_idx <= 3'd0;
          if (r_wait_high) begin
            if (w_rx_s) r_wait_high <= 1'b0;
          end else if (!w_rx_s) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (!w_rx_s) r_wait_high <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte      = r_shift;
  assign o_byte_ok   = (r_state == ST_STOP) && w_tick && w_rx_s;
  assign o_frame_err = (r_state == ST_STOP) && w_tick && !w_rx_s;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: rtl/led_cmd_rx.sv
// LED command receiver: decodes bytes from uart_rx_byte into a held 3-bit
// command with one-cycle valid / command-error / framing-error pulses.
module led_cmd_rx
  import led_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / BAUD;

  logic [7:0] w_byte;
  logic       w_byte_ok;
  logic       w_frame_err;
  logic       w_busy;
  cmd_dec_t   w_dec;

  logic [2:0] r_cmd;
  logic       r_cmd_valid;
  logic       r_cmd_err;
  logic       r_frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_ok   (w_byte_ok),
    .o_frame_err (w_frame_err),
    .o_busy      (w_busy)
  );

  assign w_dec = decode_cmd(w_byte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= 3'b000;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= w_byte_ok && w_dec.ok;
      r_cmd_err   <= w_byte_ok && !w_dec.ok;
      r_frame_err <= w_frame_err;
      if (w_byte_ok && w_dec.ok) r_cmd <= w_dec.val;
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign frame_err = r_frame_err;
  assign busy      = w_busy;

endmodule

// File: tb/tb_led_cmd_rx.sv
// Directed bench for led_cmd_rx at DIV = 10: table of single frames plus
// hand-written back-to-back, glitch, break and mid-frame reset sequences.
module tb_led_cmd_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [2:0] cmd;
  logic       cmd_valid, cmd_err, frame_err, busy;

  led_cmd_rx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, history of cmd at each valid, and rule violations.
  int         nv = 0, ne = 0, nf = 0, viol = 0, last_pulse = 0;
  logic [2:0] vq[$];
  logic       p_v = 1'b0, p_e = 1'b0, p_f = 1'b0;
  always @(negedge clk) begin
    if (cmd_valid) begin nv++; vq.push_back(cmd); last_pulse = cyc; end
    if (cmd_err)   begin ne++; last_pulse = cyc; end
    if (frame_err) begin nf++; last_pulse = cyc; end
    if ((int'(cmd_valid) + int'(cmd_err) + int'(frame_err)) > 1) viol++;
    if ((cmd_valid && p_v) || (cmd_err && p_e) || (frame_err && p_f)) viol++;
    p_v = cmd_valid; p_e = cmd_err; p_f = frame_err;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge. abort_bit >= 0
  // asserts reset in the middle of that data bit and returns early.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int abort_bit, output int t0);
    t0 = cyc;
    rx = 1'b0;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        idle(3);
        reset = 1'b1;
        idle(2);
        return;
      end
      idle(10);
    end
    rx = stop;
    idle(10);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [2:0] cmd;
    int         nv, ne, nf;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int t0, t1, bv, be, bf;

    vecs[0]  = '{8'h35, 1'b1, 3'd5, 1, 0, 0};
    vecs[1]  = '{8'h37, 1'b1, 3'd7, 1, 0, 0};
    vecs[2]  = '{8'h43, 1'b1, 3'd0, 1, 0, 0};
    vecs[3]  = '{8'h32, 1'b1, 3'd2, 1, 0, 0};
    vecs[4]  = '{8'h41, 1'b1, 3'd2, 0, 1, 0};
    vecs[5]  = '{8'h33, 1'b0, 3'd2, 0, 0, 1};
    vecs[6]  = '{8'h63, 1'b1, 3'd0, 1, 0, 0};
    vecs[7]  = '{8'h30, 1'b1, 3'd0, 1, 0, 0};
    vecs[8]  = '{8'h30, 1'b1, 3'd0, 1, 0, 0};
    vecs[9]  = '{8'h38, 1'b1, 3'd0, 0, 1, 0};
    vecs[10] = '{8'h2F, 1'b1, 3'd0, 0, 1, 0};
    vecs[11] = '{8'h36, 1'b1, 3'd6, 1, 0, 0};
    vecs[12] = '{8'h00, 1'b1, 3'd6, 0, 1, 0};
    vecs[13] = '{8'hFF, 1'b1, 3'd6, 0, 1, 0};
    vecs[14] = '{8'h31, 1'b0, 3'd6, 0, 0, 1};
    vecs[15] = '{8'h34, 1'b1, 3'd4, 1, 0, 0};

    idle(3);
    chk("reset_cmd", int'(cmd), 0);
    chk("reset_flags", int'({cmd_valid, cmd_err, frame_err}), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    idle(5);

    for (int i = 0; i < 16; i++) begin
      bv = nv; be = ne; bf = nf;
      send_frame(vecs[i].b, vecs[i].stop, -1, t0);
      idle(5);
      chk($sformatf("vec%0d_cmd", i), int'(cmd), int'(vecs[i].cmd));
      chk($sformatf("vec%0d_valid", i), nv - bv, vecs[i].nv);
      chk($sformatf("vec%0d_cmderr", i), ne - be, vecs[i].ne);
      chk($sformatf("vec%0d_frameerr", i), nf - bf, vecs[i].nf);
      chk($sformatf("vec%0d_latency", i), last_pulse - t0, 98);
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // '7' then 'C' with no idle gap between frames.
    bv = nv; be = ne; bf = nf;
    send_frame(8'h37, 1'b1, -1, t0);
    send_frame(8'h43, 1'b1, -1, t1);
    idle(5);
    chk("b2b_valid", nv - bv, 2);
    chk("b2b_first", int'(vq[vq.size()-2]), 7);
    chk("b2b_second", int'(vq[vq.size()-1]), 0);
    chk("b2b_latency", last_pulse - t1, 98);
    chk("b2b_errs", (ne - be) + (nf - bf), 0);

    // Three-cycle low glitch is rejected in START.
    bv = nv; be = ne; bf = nf;
    rx = 1'b0;
    idle(3);
    chk("glitch_busy_hi", int'(busy), 1);
    rx = 1'b1;
    idle(20);
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_pulses", (nv - bv) + (ne - be) + (nf - bf), 0);

    // Break: one frame error, then re-arm once the line returns high.
    bv = nv; be = ne; bf = nf;
    rx = 1'b0;
    idle(250);
    chk("break_frameerr", nf - bf, 1);
    chk("break_other", (nv - bv) + (ne - be), 0);
    rx = 1'b1;
    idle(5);
    chk("break_busy", int'(busy), 0);
    send_frame(8'h31, 1'b1, -1, t0);
    idle(5);
    chk("rearm_cmd", int'(cmd), 1);
    chk("rearm_valid", nv - bv, 1);

    // Reset during data bit 4 of '6', then '2'.
    bv = nv; be = ne; bf = nf;
    send_frame(8'h36, 1'b1, 4, t0);
    chk("midrst_cmd", int'(cmd), 0);
    chk("midrst_busy", int'(busy), 0);
    rx = 1'b1;
    reset = 1'b0;
    idle(5);
    chk("midrst_pulses", (nv - bv) + (ne - be) + (nf - bf), 0);
    chk("midrst_cmd_after", int'(cmd), 0);
    send_frame(8'h32, 1'b1, -1, t0);
    idle(5);
    chk("midrst_send2_cmd", int'(cmd), 2);
    chk("midrst_send2_valid", nv - bv, 1);
    chk("midrst_send2_errs", (ne - be) + (nf - bf), 0);

    chk("pulse_rules", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
